// File: rtl/turbo_deinterleaver.sv
// rtl/turbo_deinterleaver.sv - QPP block de-interleaver with on-the-fly permutation recursion
module turbo_deinterleaver #(
    parameter int K  = 40,
    parameter int F1 = 3,
    parameter int F2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    input  logic [3:0]  control_bus_in,
    output logic        data_out,
    output logic [3:0]  control_bus_out,
    output logic [12:0] addr_out
);

    localparam int AW       = $clog2(K);
    // Recursion seeds reduced at elaboration with the same single conditional subtract
    localparam int G0_SUM   = F1 + F2;
    localparam int G0       = (G0_SUM >= K) ? G0_SUM - K : G0_SUM;
    localparam int INC_SUM  = 2 * F2;
    localparam int INC      = (INC_SUM >= K) ? INC_SUM - K : INC_SUM;
    localparam int G1_SUM   = G0 + INC;
    localparam int G1       = (G1_SUM >= K) ? G1_SUM - K : G1_SUM;

    localparam logic [13:0] K_W     = 14'(K);
    localparam logic [12:0] K_END   = 13'(K);
    localparam logic [12:0] K_LAST  = 13'(K - 1);
    localparam logic [12:0] G0_W    = 13'(G0);
    localparam logic [12:0] G1_W    = 13'(G1);
    localparam logic [12:0] INC_W   = 13'(INC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t      r_state;
    logic [12:0] r_i;       // beats written in the current block
    logic [12:0] r_pi;      // write address for the next beat
    logic [12:0] r_g;       // first difference of pi
    logic [12:0] r_j;       // read address
    logic        r_data;
    logic        r_valid;
    logic        r_sob;
    logic        r_eob;
    logic        r_busy;
    logic        r_mem [0:K-1];

    logic        w_valid;
    logic        w_sob;
    logic        w_collecting;
    logic        w_start;
    logic        w_beat;
    logic        w_we;
    logic [12:0] w_waddr;
    logic [13:0] w_pi_sum;
    logic [13:0] w_pi_red;
    logic [13:0] w_g_sum;
    logic [13:0] w_g_red;
    logic        w_unused;

    assign w_valid      = control_bus_in[0];
    assign w_sob        = control_bus_in[1];
    // The cycle after the final beat is still WRITE (r_i == K) but no longer accepts input
    assign w_collecting = (r_state == S_WRITE) && (r_i != K_END);
    assign w_start      = w_valid && w_sob && ((r_state == S_IDLE) || w_collecting);
    assign w_beat       = w_valid && !w_sob && w_collecting;
    assign w_we         = w_start || w_beat;
    assign w_waddr      = w_start ? 13'd0 : r_pi;

    // pi and g advance by one add and at most one subtract of K
    assign w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
    assign w_pi_red = (w_pi_sum >= K_W) ? (w_pi_sum - K_W) : w_pi_sum;
    assign w_g_sum  = {1'b0, r_g} + {1'b0, INC_W};
    assign w_g_red  = (w_g_sum >= K_W) ? (w_g_sum - K_W) : w_g_sum;

    assign w_unused = &{1'b0, control_bus_in[3:2], w_pi_red[13], w_g_red[13]};

    // Block buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr[AW-1:0]] <= data_in;
        end
    end

    // Control FSM: collect a block, then stream it out in natural order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_pi    <= '0;
            r_g     <= '0;
            r_j     <= '0;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_sob   <= 1'b0;
            r_eob   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_i     <= 13'd1;
                        r_pi    <= G0_W;
                        r_g     <= G1_W;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_i == K_END) begin
                        r_i     <= '0;
                        r_pi    <= '0;
                        r_g     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
                    end else if (w_start) begin
                        r_i  <= 13'd1;
                        r_pi <= G0_W;
                        r_g  <= G1_W;
                    end else if (w_beat) begin
                        r_i  <= r_i + 13'd1;
                        r_pi <= w_pi_red[12:0];
                        r_g  <= w_g_red[12:0];
                    end
                end
                S_READ: begin
                    if (r_j != K_END) begin
                        r_data  <= r_mem[r_j[AW-1:0]];
                        r_valid <= 1'b1;
                        r_sob   <= (r_j == 13'd0);
                        r_eob   <= (r_j == K_LAST);
                        r_j     <= r_j + 13'd1;
                    end else begin
                        r_data  <= 1'b0;
                        r_valid <= 1'b0;
                        r_sob   <= 1'b0;
                        r_eob   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_j     <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out        = r_data;
    assign control_bus_out = {r_busy, r_eob, r_sob, r_valid};
    assign addr_out        = r_pi;

endmodule

// File: doc/turbo_deinterleaver.md
Name: turbo_deinterleaver

Overview:
- Inverse of the interleaver stage. It accepts a serial block of K bits in interleaved order, where input bit i belongs to original position pi(i). It emits the block in original order.
- The QPP permutation pi(i) = (F1*i + F2*i^2) mod K is generated on the fly by recursion. No ROM is used.
- Single block buffer with an FSM. It sits at the receive end of the same 4-bit control-bus stream protocol used by the interleaver.

Parameters:
- K, 40, block length in bits; 40..6144; must fit in 13 bits.
- F1, 3, QPP linear coefficient; 0 <= F1 < K.
- F2, 10, QPP quadratic coefficient; 0 <= F2 < K.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial interleaved data bit.
- control_bus_in  input  4  [0] valid, [1] start-of-block (sob), [3:2] reserved and ignored.
- data_out  output  1  serial de-interleaved data bit (registered).
- control_bus_out  output  4  [0] valid, [1] sob, [2] end-of-block (eob), [3] busy.
- addr_out  output  13  current buffer write address pi(i), for debug/verification.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; memory contents are don't-care.
  - All counters clear.
  - data_out=0, control_bus_out=4'b0000, addr_out=0.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - busy=0.
  - Accepted beat (valid=1 and sob=1): write data_in to mem[0], set i=1, pi=g0, g=(g0+inc) mod K, go to WRITE.
  - g0=(F1+F2) mod K; inc=(2*F2) mod K.
  - valid=1 with sob=0: dropped.
- WRITE:
  - busy=0.
  - Each valid beat writes data_in to mem[pi], then advances i and the pi/g recursion.
  - valid=0: no change (gaps allowed).
  - sob=1 with valid=1: restart the block. The partial block is discarded, the beat is written to mem[0], and the recursion restarts as in IDLE.
  - When the beat with i=K-1 is written, go to READ on the next edge.
- Recursion arithmetic:
  - pi_next = pi+g; subtract K if the result >= K. g_next is computed the same way using inc.
  - Intermediate sums are 14-bit; the conditional subtract is the only reduction.
  - Never use a multiplier or a modulo operator.
- addr_out shows the pi value that will be used by the next write. It holds 0 outside WRITE.
- READ:
  - busy=1; control_bus_in and data_in are ignored and input beats are dropped.
  - Read address j runs from 0 to K-1, one per cycle, with no downstream backpressure.
  - Memory read is synchronous. data_out for address j is registered one cycle after j is issued.
- Output timing:
  - If the last input beat is sampled at edge T, READ is entered at edge T+1.
  - data_out for j=0 becomes valid after edge T+2. Bit j is valid after edge T+2+j.
- Output control flags:
  - control_bus_out[0] is 1 exactly for the K output cycles.
  - [1] is 1 with bit 0 only; [2] is 1 with bit K-1 only.
- After the eob cycle:
  - busy drops and the FSM returns to IDLE on the same edge that removes eob.
  - The next sob can be accepted one cycle after eob.
- busy timing:
  - Rises at edge T+1.
  - Stays high through the eob output cycle.
- reset asserted mid-WRITE or mid-READ: immediate return to IDLE with reset values. The interrupted block is never emitted.
- Storage: K x 1 bit register array or inferred RAM, one write port and one read port. A write and a read never occur in the same cycle.

Test Plan:
- Recursion check, K=40, F1=3, F2=10: stream 40 valid beats.
  - Required addr_out sequence: 0, 13, 6, 19, ...
  - Every addr_out value must equal (3i+10i^2) mod 40, and all 40 values must be distinct.
- Single-one impulse: data_in=1 only at input beat i=1, all other beats 0.
  - Required response: data_out=1 only on output bit 13; sob on bit 0; eob on bit 39.
- Loopback through the interleaver: random 40-bit block, interleaved then deinterleaved.
  - Required response: output equals the original block.
  - First output appears exactly 2 cycles after the last input edge.
- Gapped input with random valid deassertions: same output as the gap-free run.
  - Beats sent while busy=1 are dropped, and output stays unchanged.
- Restart: sob mid-WRITE at i=17, then a full 40-beat block.
  - Required response: only the second block is emitted, with correct content.
- Reset at READ output bit 20: outputs go to 0 immediately.
  - A following fresh block is emitted in full and correct.
- Large block: K=6144, F1=263, F2=480.
  - Required response: impulse at i=1 appears at output position 743, and the FSM returns to IDLE after 6144 outputs.
